ms_timer_param: RTL and testbench
=================================

# ms_timer_param

Parametrised minutes:seconds countdown timer for the microwave controller timer path. It chains BCD digit counters (seconds units mod 10, seconds tens mod 6, and `MIN_DIGITS` minute digits mod 10) into one down-counting timer. It adds an input prescaler, preset sanitising, selectable hold/wrap at zero, and a completion pulse. It sits between the keypad/preset logic and the display/heater control, and exposes the live BCD time and zero/done status.

## Interface

Parameters:
- `MIN_DIGITS`, 2: number of BCD minute digits (1–4). Total digits D = MIN_DIGITS+2.
- `TICK_DIV`, 1: number of `enab` pulses per one-second decrement (1–1023).
- `WRAP`, 0: behaviour on a tick at 00:00. 0 = hold at zero. 1 = wrap to all-max (9…9:59).

Ports:
- `clk`, input, 1: rising-edge clock.
- `clear`, input, 1: asynchronous, active-low reset of all state.
- `load`, input, 1: synchronous, active-low preset load.
- `enab`, input, 1: tick enable, one-cycle pulse per prescaler count.
- `numero`, input, 4·D: BCD preset. Nibble 0 is seconds units, nibble 1 is seconds tens, nibbles 2.. are minutes, LS first.
- `numero_saida`, output, 4·D: current BCD time, same layout as `numero`.
- `zero_saida`, output, 1: high while every digit is 0.
- `tc_saida`, output, 1: high while at zero and `enab` is high with the prescaler at terminal, i.e. the next tick would underflow.
- `done_saida`, output, 1: one-cycle pulse on the transition into zero by counting.

## Operation

- Priority per edge: `clear` (async) > `load` low > count > hold.
- Reset: all digits 0 and prescaler 0. `zero_saida`=1, `done_saida`=0, `tc_saida`=`enab` when `TICK_DIV`=1, else 0.
- Load: each digit is captured and sanitised.
  - Seconds units and minute digits: >9 → 9.
  - Seconds tens: >5 → 5.
  - Prescaler is cleared. `done_saida` stays 0, even when the loaded value is zero.
- Prescaler: counts `enab` pulses from 0 to `TICK_DIV`−1. A tick is `enab` with the prescaler at `TICK_DIV`−1; the prescaler then returns to 0. If `enab`=0, the prescaler holds.
- Decrement on a tick when not at zero:
  - The units digit decrements. Each digit borrows from the next only when every lower digit is 0.
  - A borrowing digit reloads its maximum: 9 for units and minutes, 5 for seconds tens.
  - Examples: 01:00 → 00:59; 10:00 → 09:59.
- Tick at zero:
  - `WRAP`=0: value holds, no `done_saida`.
  - `WRAP`=1: value loads all-max, e.g. 99:59 for `MIN_DIGITS`=2. `done_saida` stays 0.
- `done_saida` is registered. It is 1 for exactly the cycle after the edge where the value went from nonzero to zero by a tick.
- `zero_saida` is combinational from the digit registers.
- `tc_saida` is combinational: zero AND `enab` AND prescaler terminal.

## Timing

- Tick-to-output latency: 1 clock. `numero_saida` changes on the same edge that samples the qualifying `enab`.
- Load latency: 1 clock. The preset is visible after the edge sampling `load`=0.
- `load` low and a tick in the same cycle: load wins, and the tick is discarded, including its prescaler count.
- `clear` asserted mid-count: outputs go to reset values immediately, with no clock needed. Release is synchronised externally. The first tick after release needs the full `TICK_DIV` pulses.
- `done_saida` is never high for two consecutive cycles. A load in the done cycle clears it on the next edge.
- All digits are registered. Valid codes are guaranteed at all times: sanitising on load plus borrow-only arithmetic means no digit ever exceeds its modulus.

## Test plan

- Reset: pulse `clear` low mid-count at 03:27 → `numero_saida`=0, `zero_saida`=1, `done_saida`=0 without a clock edge.
- Load and borrow (`MIN_DIGITS`=2, `TICK_DIV`=1): load 10:00, then 1 tick → 09:59. 59 further ticks → 09:00. 1 more → 08:59.
- Completion: load 00:02, then 2 ticks → 00:00 with `done_saida` high for exactly 1 cycle. A 3rd tick keeps 00:00 with no done (`WRAP`=0). With `WRAP`=1 the 3rd tick → 99:59.
- Sanitise: load nibbles {units=C, tens=7, min0=F, min1=A} → 99:59.
- Prescaler (`TICK_DIV`=4): load 00:05 and give 7 `enab` pulses → 00:04. Load 00:05 on pulse 8; pulses 8–11 → 00:05 held until pulse 12, then 00:04.
- Simultaneous load and tick at 00:01: result is the preset value, `done_saida`=0. `tc_saida`=1 only when at 00:00 with `enab` high.

Source files
------------

// File: rtl/ms_timer_param.sv
// rtl/ms_timer_param.sv - BCD minutes:seconds countdown timer with prescaler, preset sanitising and hold/wrap at zero
module ms_timer_param #(
  parameter int MIN_DIGITS = 2,
  parameter int TICK_DIV   = 1,
  parameter bit WRAP       = 1'b0
) (
  input  logic                        clk,
  input  logic                        clear,
  input  logic                        load,
  input  logic                        enab,
  input  logic [4*(MIN_DIGITS+2)-1:0] numero,
  output logic [4*(MIN_DIGITS+2)-1:0] numero_saida,
  output logic                        zero_saida,
  output logic                        tc_saida,
  output logic                        done_saida
);

  localparam int D  = MIN_DIGITS + 2;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_TERM = PW'(TICK_DIV - 1);

  logic [D-1:0][3:0] digit;
  logic [D-1:0][3:0] dec;
  logic [D-1:0][3:0] sane;
  logic [D-1:0][3:0] maxv;
  logic [D:0]        borrow;
  logic [PW-1:0]     pre;
  logic              terminal;
  logic              tick;
  logic              dec_zero;

  // Ripple-borrow decrement: a digit only moves when every lower digit is 0.
  always_comb begin
    dec    = '0;
    sane   = '0;
    maxv   = '0;
    borrow = '0;
    borrow[0] = 1'b1;
    for (int i = 0; i < D; i++) begin
      maxv[i] = (i == 1) ? 4'd5 : 4'd9;
      sane[i] = (numero[4*i +: 4] > maxv[i]) ? maxv[i] : numero[4*i +: 4];
      if (borrow[i]) begin
        if (digit[i] == 4'd0) begin
          dec[i]      = maxv[i];
          borrow[i+1] = 1'b1;
        end else begin
          dec[i]      = digit[i] - 4'd1;
          borrow[i+1] = 1'b0;
        end
      end else begin
        dec[i]      = digit[i];
        borrow[i+1] = 1'b0;
      end
    end
  end

  assign dec_zero     = (dec == '0);
  assign zero_saida   = (digit == '0);
  assign terminal     = (pre == PRE_TERM);
  assign tick         = enab & terminal;
  assign tc_saida     = zero_saida & tick;
  assign numero_saida = digit;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      digit      <= '0;
      pre        <= '0;
      done_saida <= 1'b0;
    end else if (!load) begin
      digit      <= sane;
      pre        <= '0;
      done_saida <= 1'b0;
    end else begin
      done_saida <= 1'b0;
      if (enab) begin
        if (terminal) begin
          pre <= '0;
          if (!zero_saida) begin
            digit      <= dec;
            done_saida <= dec_zero;
          end else if (WRAP) begin
            digit <= maxv;
          end
        end else begin
          pre <= pre + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ms_timer_param.sv
// tb/tb_ms_timer_param.sv - directed self-checking bench for ms_timer_param (hold, wrap and prescaled variants)
module tb_ms_timer_param;

  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic        load = 1'b1;
  logic        enab = 1'b0;
  logic [15:0] numero = '0;
  logic        load_c = 1'b1;
  logic        enab_c = 1'b0;
  logic [15:0] numero_c = '0;

  logic [15:0] q_a, q_b, q_c;
  logic        zero_a, zero_b, zero_c;
  logic        tc_a, tc_b, tc_c;
  logic        done_a, done_b, done_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ms_timer_param #(.MIN_DIGITS(2), .TICK_DIV(1), .WRAP(1'b0)) dut_a (
    .clk(clk), .clear(clear), .load(load), .enab(enab), .numero(numero),
    .numero_saida(q_a), .zero_saida(zero_a), .tc_saida(tc_a), .done_saida(done_a));

  ms_timer_param #(.MIN_DIGITS(2), .TICK_DIV(1), .WRAP(1'b1)) dut_b (
    .clk(clk), .clear(clear), .load(load), .enab(enab), .numero(numero),
    .numero_saida(q_b), .zero_saida(zero_b), .tc_saida(tc_b), .done_saida(done_b));

  ms_timer_param #(.MIN_DIGITS(2), .TICK_DIV(4), .WRAP(1'b0)) dut_c (
    .clk(clk), .clear(clear), .load(load_c), .enab(enab_c), .numero(numero_c),
    .numero_saida(q_c), .zero_saida(zero_c), .tc_saida(tc_c), .done_saida(done_c));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // reset state
    enab = 1'b1;
    #2;
    chk("rst_q_a", q_a, 16'h0000);
    chk("rst_zero_a", {15'd0, zero_a}, 16'd1);
    chk("rst_done_a", {15'd0, done_a}, 16'd0);
    chk("rst_tc_a", {15'd0, tc_a}, 16'd1);
    chk("rst_tc_c", {15'd0, tc_c}, 16'd0);
    enab = 1'b0;
    #10 clear = 1'b1;
    cyc(1);

    // load and borrow
    numero = 16'h1000; load = 1'b0;
    cyc(1);
    chk("load_1000", q_a, 16'h1000);
    load = 1'b1; enab = 1'b1;
    cyc(1);
    chk("borrow_0959", q_a, 16'h0959);
    chk("zero_nz", {15'd0, zero_a}, 16'd0);
    cyc(59);
    chk("count_0900", q_a, 16'h0900);
    cyc(1);
    chk("borrow_0859", q_a, 16'h0859);
    chk("b_0859", q_b, 16'h0859);

    // completion, hold and wrap
    enab = 1'b0; numero = 16'h0002; load = 1'b0;
    cyc(1);
    load = 1'b1; enab = 1'b1;
    cyc(1);
    chk("cmp_0001", q_a, 16'h0001);
    chk("cmp_done0", {15'd0, done_a}, 16'd0);
    cyc(1);
    chk("cmp_0000", q_a, 16'h0000);
    chk("cmp_done1", {15'd0, done_a}, 16'd1);
    chk("cmp_done1_b", {15'd0, done_b}, 16'd1);
    chk("cmp_tc1", {15'd0, tc_a}, 16'd1);
    cyc(1);
    chk("hold_0000", q_a, 16'h0000);
    chk("hold_done0", {15'd0, done_a}, 16'd0);
    chk("wrap_9959", q_b, 16'h9959);
    chk("wrap_done0", {15'd0, done_b}, 16'd0);
    enab = 1'b0;
    #1;
    chk("tc_noenab", {15'd0, tc_a}, 16'd0);

    // sanitise
    numero = 16'hAF7C; load = 1'b0;
    cyc(1);
    chk("sanitise", q_a, 16'h9959);
    chk("sanitise_tc", {15'd0, tc_a}, 16'd0);

    // simultaneous load and tick at 00:01
    numero = 16'h0001;
    cyc(1);
    numero = 16'h0000; enab = 1'b1;
    cyc(1);
    chk("ldtick_q", q_a, 16'h0000);
    chk("ldtick_done", {15'd0, done_a}, 16'd0);
    numero = 16'h0042;
    cyc(1);
    chk("ldtick_0042", q_a, 16'h0042);

    // async clear mid-count at 03:27
    numero = 16'h0328;
    cyc(1);
    load = 1'b1;
    cyc(1);
    chk("pre_clear", q_a, 16'h0327);
    #2 clear = 1'b0;
    #1;
    chk("clr_q", q_a, 16'h0000);
    chk("clr_zero", {15'd0, zero_a}, 16'd1);
    chk("clr_done", {15'd0, done_a}, 16'd0);
    enab = 1'b0;
    #3 clear = 1'b1;
    cyc(1);

    // prescaler
    numero_c = 16'h0005; load_c = 1'b0;
    cyc(1);
    load_c = 1'b1; enab_c = 1'b1;
    cyc(3);
    chk("pre_p3", q_c, 16'h0005);
    cyc(1);
    chk("pre_p4", q_c, 16'h0004);
    cyc(3);
    chk("pre_p7", q_c, 16'h0004);
    load_c = 1'b0;
    cyc(1);
    chk("pre_p8_load", q_c, 16'h0005);
    load_c = 1'b1;
    cyc(3);
    chk("pre_p11", q_c, 16'h0005);
    cyc(1);
    chk("pre_p12", q_c, 16'h0004);

    // prescaled completion and tc gating
    enab_c = 1'b0; numero_c = 16'h0001; load_c = 1'b0;
    cyc(1);
    load_c = 1'b1; enab_c = 1'b1;
    cyc(3);
    chk("pc_p3", q_c, 16'h0001);
    chk("pc_done0", {15'd0, done_c}, 16'd0);
    cyc(1);
    chk("pc_0000", q_c, 16'h0000);
    chk("pc_done1", {15'd0, done_c}, 16'd1);
    chk("pc_tc0", {15'd0, tc_c}, 16'd0);
    cyc(2);
    chk("pc_tc_pre2", {15'd0, tc_c}, 16'd0);
    chk("pc_done_gone", {15'd0, done_c}, 16'd0);
    cyc(1);
    chk("pc_tc_pre3", {15'd0, tc_c}, 16'd1);
    cyc(1);
    chk("pc_hold", q_c, 16'h0000);
    chk("pc_tc_wrapped", {15'd0, tc_c}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
